// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - FSM state encodings (plain localparam constants)
//   - oversampling constants: OVERSAMPLE ticks per bit, MID_SAMPLE tick index
//   - DEFAULT_CLK_DIV for a 100 MHz system clock at 115200 baud x16
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int OVERSAMPLE      = 16;
  localparam int MID_SAMPLE      = 8;
  localparam int DEFAULT_CLK_DIV = 54;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side register interface of the UART receiver.
//   RX_Read_en        consumer acknowledge (clears valid and sticky flags)
//   RX_Data_Register  last accepted word
//   RX_Data_Valid     register holds an unread word
//   RX_Frame_Error    sticky, stop bit sampled low
//   RX_Overrun        sticky, frame completed while a word was unread
//   RX_Busy           receiver FSM not idle
//   RX_Parity_Error   sticky, parity mismatch (0 when parity is not built in)
// Modports: slave = receiver side, master = consumer side.
interface uart_rx_if #(
  parameter int WORD_SIZE = 8
);
  logic                 RX_Read_en;
  logic [WORD_SIZE-1:0] RX_Data_Register;
  logic                 RX_Data_Valid;
  logic                 RX_Frame_Error;
  logic                 RX_Overrun;
  logic                 RX_Busy;
  logic                 RX_Parity_Error;

  modport slave (
    input  RX_Read_en,
    output RX_Data_Register, RX_Data_Valid, RX_Frame_Error,
           RX_Overrun, RX_Busy, RX_Parity_Error
  );

  modport master (
    output RX_Read_en,
    input  RX_Data_Register, RX_Data_Valid, RX_Frame_Error,
           RX_Overrun, RX_Busy, RX_Parity_Error
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle oversample tick.
//   clk      system clock
//   reset_b  asynchronous active-low reset
//   restart  synchronous restart, counter returns to 0 (phase alignment)
//   tick     high for one cycle when the counter is at CLK_DIV-1
module uart_baud_tick #(
  parameter int CLK_DIV = 54
) (
  input  logic clk,
  input  logic reset_b,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart || cnt_q == TERM) cnt_d = '0;
  end

  // A restart cycle never emits a tick, so the first tick after a start edge
  // arrives a full CLK_DIV clocks later.
  assign tick = (cnt_q == TERM) && !restart;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, 8N1 by default, LSB first.
//   clk         system clock
//   reset_b     asynchronous active-low reset
//   RX_Data_in  serial line, idle high, asynchronous to clk
//   rx_if       consumer register interface (slave modport)
// Optional feature: define UART_RX_PARITY_EN to receive an even parity bit
// between the data and stop bits; otherwise RX_Parity_Error is tied 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WORD_SIZE       = 8,
  parameter int WORD_SIZE_WIDTH = 4,
  parameter int CLK_DIV         = DEFAULT_CLK_DIV
) (
  input  logic     clk,
  input  logic     reset_b,
  input  logic     RX_Data_in,
  uart_rx_if.slave rx_if
);

  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID  = 4'(MID_SAMPLE - 1);
  localparam logic [WORD_SIZE_WIDTH-1:0] BIT_LAST = WORD_SIZE_WIDTH'(WORD_SIZE - 1);

  logic                       sync1_q, sync2_q;
  logic                       rx_s;
  logic [2:0]                 state_q, state_d;
  logic [3:0]                 os_q, os_d;
  logic [WORD_SIZE_WIDTH-1:0] bit_q, bit_d;
  logic [WORD_SIZE-1:0]       shift_q, shift_d;
  logic [WORD_SIZE-1:0]       data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       fe_q, fe_d;
  logic                       ovr_q, ovr_d;
  logic                       armed_q, armed_d;
  logic                       restart, tick;
  logic                       stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                       perr_q, perr_d;
  logic                       par_bad;
`endif

  assign rx_s = sync2_q;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_b (reset_b),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fe_d     = fe_q;
    ovr_d    = ovr_q;
    armed_d  = armed_q;
    restart  = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
    par_bad  = 1'b0;
`endif

    if (tick) os_d = os_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        // armed only after the line has been seen high, so a held-low line
        // (break) produces a single frame error instead of repeated frames
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          restart = 1'b1;
          os_d    = '0;
          armed_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick && os_q == OS_MID) begin
          if (rx_s) begin
            state_d = ST_IDLE;          // glitch, not a start bit
            armed_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            os_d    = '0;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick && os_q == OS_LAST) begin
          // right shift: the first (LSB) bit ends up in bit 0 after WORD_SIZE shifts
          shift_d = {rx_s, shift_q[WORD_SIZE-1:1]};
          bit_d   = bit_q + WORD_SIZE_WIDTH'(1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick && os_q == OS_LAST) begin
          par_bad = ^{shift_q, rx_s};
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // back to IDLE at mid stop bit so the next start edge is not missed
        if (tick && os_q == OS_LAST) begin
          state_d  = ST_IDLE;
          armed_d  = rx_s;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A read clears valid and the sticky flags; events in the same cycle win.
    if (rx_if.RX_Read_en) begin
      valid_d = 1'b0;
      fe_d    = 1'b0;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
    if (stop_ok) begin
      if (!valid_q || rx_if.RX_Read_en) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (stop_bad) fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (par_bad) perr_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= RX_Data_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      armed_q <= armed_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end
  assign rx_if.RX_Parity_Error = perr_q;
`else
  assign rx_if.RX_Parity_Error = 1'b0;
`endif

  assign rx_if.RX_Data_Register = data_q;
  assign rx_if.RX_Data_Valid    = valid_q;
  assign rx_if.RX_Frame_Error   = fe_q;
  assign rx_if.RX_Overrun       = ovr_q;
  assign rx_if.RX_Busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLK_DIV=4 (64 clocks per bit).
// Table-driven single frames plus hand-written glitch, overrun,
// read-on-completion, mid-frame reset and (optionally) parity sequences.
module tb_uart_rx;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = CLK_DIV * 16;
  // Negedge index (from the start-bit negedge) just before the clock edge
  // that samples mid stop bit: 2 sync + 8*4 start + 16*4 per later bit.
`ifdef UART_RX_PARITY_EN
  localparam int DONE_NEG = 674;
`else
  localparam int DONE_NEG = 610;
`endif

  logic clk     = 1'b0;
  logic reset_b = 1'b0;
  logic rx_line = 1'b1;

  uart_rx_if #(.WORD_SIZE(8)) rx_if ();

  uart_rx #(.WORD_SIZE(8), .WORD_SIZE_WIDTH(4), .CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .RX_Data_in (rx_line),
    .rx_if      (rx_if.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_reg;
    logic       exp_valid;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [7:0] r, input logic v,
                           input logic fe, input logic ov, input logic pe, input logic busy);
    chk({tag, "/reg"},   32'(rx_if.RX_Data_Register), 32'(r));
    chk({tag, "/valid"}, 32'(rx_if.RX_Data_Valid),    32'(v));
    chk({tag, "/fe"},    32'(rx_if.RX_Frame_Error),   32'(fe));
    chk({tag, "/ovr"},   32'(rx_if.RX_Overrun),       32'(ov));
    chk({tag, "/perr"},  32'(rx_if.RX_Parity_Error),  32'(pe));
    chk({tag, "/busy"},  32'(rx_if.RX_Busy),          32'(busy));
  endtask

  // Called at a negedge; drives the start bit immediately.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    rx_line = 1'b0;
    wait_neg(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      wait_neg(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx_line = (^d) ^ par_flip;
    wait_neg(BIT_CLKS);
`else
    if (par_flip) rx_line = 1'b1;
`endif
    rx_line = stop;
    wait_neg(BIT_CLKS);
    rx_line = 1'b1;
  endtask

  task automatic pulse_read;
    rx_if.RX_Read_en = 1'b1;
    @(negedge clk);
    rx_if.RX_Read_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_reg: 8'hA5, exp_valid: 1'b1, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_reg: 8'hA5, exp_valid: 1'b0, exp_fe: 1'b1};
    vecs[2] = '{data: 8'h96, stop: 1'b1, exp_reg: 8'h96, exp_valid: 1'b1, exp_fe: 1'b0};

    rx_if.RX_Read_en = 1'b0;
    reset_b = 1'b0;
    wait_neg(3);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_b = 1'b1;
    wait_neg(10);

    // table-driven single frames, each followed by a read
    for (int k = 0; k < 3; k++) begin
      send_frame(vecs[k].data, vecs[k].stop, 1'b0);
      wait_neg(32);
      check_out($sformatf("vec%0d", k), vecs[k].exp_reg, vecs[k].exp_valid,
                vecs[k].exp_fe, 1'b0, 1'b0, 1'b0);
      pulse_read();
      check_out($sformatf("vec%0d_rd", k), vecs[k].exp_reg, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 20-clock low glitch on the idle line
    rx_line = 1'b0;
    wait_neg(10);
    chk("glitch/busy_mid", 32'(rx_if.RX_Busy), 32'd1);
    wait_neg(10);
    rx_line = 1'b1;
    wait_neg(100);
    check_out("glitch", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back frames without reads -> overrun, first word kept
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_neg(32);
    check_out("ovr", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_read();
    check_out("ovr_rd", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // read on the completion cycle of the second frame: completion wins
    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        wait_neg(DONE_NEG);
        chk("rdc/busy_before",  32'(rx_if.RX_Busy),       32'd1);
        chk("rdc/valid_before", 32'(rx_if.RX_Data_Valid), 32'd1);
        rx_if.RX_Read_en = 1'b1;
        @(negedge clk);
        rx_if.RX_Read_en = 1'b0;
        chk("rdc/busy_after", 32'(rx_if.RX_Busy), 32'd0);
      end
    join
    wait_neg(32);
    check_out("rdc", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-DATA of 0xFF (valid=1 with 0x22 beforehand)
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        wait_neg(200);
        chk("rst/busy_before", 32'(rx_if.RX_Busy), 32'd1);
        reset_b = 1'b0;
        #1;
        check_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_neg(3);
        reset_b = 1'b1;
      end
    join
    wait_neg(32);
    check_out("rst_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_neg(32);
    check_out("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_read();

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight; parity bit 0 is wrong for even parity
    send_frame(8'h07, 1'b1, 1'b1);
    wait_neg(32);
    check_out("parity", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_read();
    check_out("parity_rd", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
